// File: rtl/kalman_fx_pkg.sv
// Shared Q2.14 fixed-point definitions for the Kalman datapath blocks.
// Holds widths, saturation limits, the inverse FSM states and clamping.
package kalman_fx_pkg;

  localparam int W    = 16;
  localparam int FRAC = 14;
  localparam int NW   = W + 2 * FRAC;
  localparam int DW   = 32;

  localparam logic [W-1:0] Q_ONE = 16'd16384;
  localparam logic [W-1:0] Q_MAX = 16'd32767;

  typedef enum logic [1:0] {
    IDLE,
    DET,
    DIV,
    DONE
  } state_e;

  // Unsigned quotient magnitude -> Q2.14 magnitude, clamped to Q_MAX.
  function automatic logic [W-1:0] sat_mag(
    input logic [NW-1:0] mag
  );
    return (mag > NW'(Q_MAX)) ? Q_MAX : mag[W-1:0];
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The load cycle already performs the first step, so valid follows NW cycles later.
module seq_udiv #(
  parameter int NW = 44,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quo,
  output logic          valid
);

  localparam int CW = $clog2(NW + 1);

  logic [DW-1:0] r_q;
  logic [NW-1:0] q_q;
  logic [DW-1:0] d_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          valid_q;

  logic [DW-1:0] r_src;
  logic [NW-1:0] q_src;
  logic [DW-1:0] d_src;
  logic [DW:0]   r_sh;
  logic          ge;
  logic [DW-1:0] r_d;
  logic [NW-1:0] q_d;

  always_comb begin
    r_src = load ? '0 : r_q;
    q_src = load ? dividend : q_q;
    d_src = load ? divisor : d_q;
    r_sh  = {r_src, q_src[NW-1]};
    ge    = r_sh >= {1'b0, d_src};
    r_d   = ge ? DW'(r_sh - {1'b0, d_src})
               : r_sh[DW-1:0];
    q_d   = {q_src[NW-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load) begin
        r_q   <= r_d;
        q_q   <= q_d;
        d_q   <= divisor;
        cnt_q <= CW'(NW - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        r_q   <= r_d;
        q_q   <= q_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q   <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign quo   = q_q;
  assign valid = valid_q;

endmodule

// File: rtl/mat2x2_inv_seq.sv
// Sequential 2x2 Q2.14 matrix inverse, C = adj(A)/det(A).
// Four entries share one serial divider; flags singular and clamped results.
module mat2x2_inv_seq
  import kalman_fx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] A11,
  input  logic signed [W-1:0] A12,
  input  logic signed [W-1:0] A21,
  input  logic signed [W-1:0] A22,
  output logic                busy,
  output logic                done,
  output logic                singular,
  output logic                sat,
  output logic signed [W-1:0] C11,
  output logic signed [W-1:0] C12,
  output logic signed [W-1:0] C21,
  output logic signed [W-1:0] C22
);

  state_e              state_q;
  logic signed [W-1:0] a_q [4];
  logic signed [W:0]   adj_q [4];
  logic signed [2*W:0] det_q;
  logic [1:0]          idx_q;
  logic                busy_q;
  logic                done_q;
  logic                sing_q;
  logic                sat_q;
  logic                sing_acc_q;
  logic                sat_acc_q;
  logic signed [W-1:0] c_q [4];

  logic signed [W:0]   adj_w [4];
  logic signed [2*W:0] det_w;
  logic signed [W:0]   adj_sel;
  logic signed [2*W:0] det_sel;
  logic [W-1:0]        adj_mag;
  logic                div_load;
  logic [NW-1:0]       div_dvd;
  logic [DW-1:0]       div_dvs;
  logic [NW-1:0]       div_quo;
  logic                div_valid;
  logic [W-1:0]        q_mag;
  logic                q_ovf;
  logic                q_neg;
  logic signed [W-1:0] q_val;

  // Negation in W+1 bits keeps -(-32768) representable.
  always_comb begin
    adj_w[0] = (W+1)'(a_q[3]);
    adj_w[1] = -((W+1)'(a_q[1]));
    adj_w[2] = -((W+1)'(a_q[2]));
    adj_w[3] = (W+1)'(a_q[0]);
    det_w    = (2*W+1)'(a_q[0]) * (2*W+1)'(a_q[3])
             - (2*W+1)'(a_q[1]) * (2*W+1)'(a_q[2]);
  end

  always_comb begin
    div_load = 1'b0;
    adj_sel  = adj_w[0];
    det_sel  = det_w;
    unique case (1'b1)
      state_q == DET: begin
        div_load = det_w != '0;
      end
      state_q == DIV: begin
        adj_sel  = adj_q[idx_q + 2'd1];
        det_sel  = det_q;
        div_load = div_valid && idx_q != 2'd3;
      end
      default: ;
    endcase
    adj_mag = adj_sel[W] ? W'(-adj_sel)
                         : adj_sel[W-1:0];
    div_dvs = det_sel[2*W] ? DW'(-det_sel)
                           : det_sel[DW-1:0];
    div_dvd = {adj_mag, (2*FRAC)'(0)};
  end

  seq_udiv #(
    .NW(NW),
    .DW(DW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (div_load),
    .dividend(div_dvd),
    .divisor (div_dvs),
    .quo     (div_quo),
    .valid   (div_valid)
  );

  always_comb begin
    q_mag = sat_mag(div_quo);
    q_ovf = div_quo > NW'(Q_MAX);
    q_neg = adj_q[idx_q][W] ^ det_q[2*W];
    q_val = q_neg ? W'(-q_mag) : q_mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      det_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sing_q     <= 1'b0;
      sat_q      <= 1'b0;
      sing_acc_q <= 1'b0;
      sat_acc_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= '0;
        adj_q[i] <= '0;
        c_q[i]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // done_q marks the DONE cycle; a start there is dropped.
          if (start && !done_q) begin
            a_q[0]  <= A11;
            a_q[1]  <= A12;
            a_q[2]  <= A21;
            a_q[3]  <= A22;
            busy_q  <= 1'b1;
            state_q <= DET;
          end
        end
        DET: begin
          det_q     <= det_w;
          idx_q     <= '0;
          sat_acc_q <= 1'b0;
          for (int i = 0; i < 4; i++) begin
            adj_q[i] <= adj_w[i];
          end
          if (det_w == '0) begin
            sing_acc_q <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              c_q[i] <= '0;
            end
            state_q <= DONE;
          end else begin
            sing_acc_q <= 1'b0;
            state_q    <= DIV;
          end
        end
        DIV: begin
          if (div_valid) begin
            c_q[idx_q] <= q_val;
            sat_acc_q  <= sat_acc_q | q_ovf;
            if (idx_q == 2'd3) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          sing_q  <= sing_acc_q;
          sat_q   <= sat_acc_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;
  assign sat      = sat_q;
  assign C11      = c_q[0];
  assign C12      = c_q[1];
  assign C21      = c_q[2];
  assign C22      = c_q[3];

endmodule

// File: tb/tb_mat2x2_inv_seq.sv
// Directed bench for mat2x2_inv_seq: vectors, latency, flags, protocol.
// Expected inverses are worked out by hand from adj(A)/det(A).
module tb_mat2x2_inv_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] a11, a12, a21, a22;
  logic               busy, done, singular, sat;
  logic signed [15:0] c11, c12, c21, c22;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat2x2_inv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A11     (a11),
    .A12     (a12),
    .A21     (a21),
    .A22     (a22),
    .busy    (busy),
    .done    (done),
    .singular(singular),
    .sat     (sat),
    .C11     (c11),
    .C12     (c12),
    .C21     (c21),
    .C22     (c22)
  );

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic set_a(input int x11, input int x12,
                       input int x21, input int x22);
    a11 = 16'(x11);
    a12 = 16'(x12);
    a21 = 16'(x21);
    a22 = 16'(x22);
  endtask

  // Start is held across exactly one rising edge (edge 0).
  task automatic launch(input int x11, input int x12,
                        input int x21, input int x22);
    @(negedge clk);
    set_a(x11, x12, x21, x22);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic check_c(input string tag,
                         input int e11, input int e12,
                         input int e21, input int e22);
    check({tag, ".C11"}, c11, e11);
    check({tag, ".C12"}, c12, e12);
    check({tag, ".C21"}, c21, e21);
    check({tag, ".C22"}, c22, e22);
  endtask

  task automatic op(input string tag,
                    input int x11, input int x12,
                    input int x21, input int x22,
                    input int e_lat,
                    input int e11, input int e12,
                    input int e21, input int e22,
                    input int e_sing, input int e_sat);
    int lat;
    launch(x11, x12, x21, x22);
    check({tag, ".busy"}, busy, 1);
    wait_done(lat);
    check({tag, ".lat"}, lat, e_lat);
    check_c(tag, e11, e12, e21, e22);
    check({tag, ".singular"}, singular, e_sing);
    check({tag, ".sat"}, sat, e_sat);
    check({tag, ".busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    set_a(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.singular", singular, 0);
    check("rst.sat", sat, 0);
    check_c("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    op("ident", 16384, 0, 0, 16384, 178,
       16384, 0, 0, 16384, 0, 0);
    op("shear", 16384, 8192, 0, 16384, 178,
       16384, -8192, 0, 16384, 0, 0);
    op("swap", 0, 16384, 16384, 0, 178,
       0, 16384, 16384, 0, 0, 0);
    op("satur", 8192, 0, 0, 8192, 178,
       32767, 0, 0, 32767, 0, 1);
    op("sing", 16384, 16384, 16384, 16384, 2,
       0, 0, 0, 0, 1, 0);

    // Start pulsed mid-operation must be ignored.
    launch(16384, 0, 16384, 16384);
    lat = 0;
    while (!done && lat < 400) begin
      if (lat == 60) begin
        set_a(8192, 0, 0, 8192);
        start = 1'b1;
      end
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
    end
    check("ign.lat", lat, 178);
    check_c("ign", 16384, 0, -16384, 16384);
    check("ign.sat", sat, 0);

    // Start presented in the done cycle is dropped.
    set_a(16384, 0, 0, 16384);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("donecyc.busy", busy, 0);
    dn = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("noqueue.dones", dn, 0);
    check_c("held", 16384, 0, -16384, 16384);

    // Asynchronous reset in the middle of DIV.
    launch(16384, 0, 0, 16384);
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.C11", c11, 0);
    check("abort.C21", c21, 0);
    dn = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("abort.dones", dn, 0);

    op("after", 16384, 8192, 0, 16384, 178,
       16384, -8192, 0, 16384, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
